// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters: A (main execute path)
// and B (address/auxiliary path). A request is accepted in IDLE, its fields are
// registered onto the alu_* bus, and the result is captured one cycle later.
// The result is then held on a valid/ready response channel, tagged with the
// requester ID, until the consumer takes it.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   a_req_valid / a_req_ready  requester A handshake
//   a_rs1, a_rs2, a_opcode, a_func3, a_func7   requester A operation fields
//   b_*                        same set of signals for requester B
//   alu_rs1 .. alu_func7       registered operands/opcode driving the shared ALU
//   alu_out                    combinational ALU result
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     0 = A, 1 = B
//   rsp_data                   captured ALU result
//   busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            a_req_valid,
    output logic            a_req_ready,
    input  logic [XLEN-1:0] a_rs1,
    input  logic [XLEN-1:0] a_rs2,
    input  logic [6:0]      a_opcode,
    input  logic [2:0]      a_func3,
    input  logic [6:0]      a_func7,

    input  logic            b_req_valid,
    output logic            b_req_ready,
    input  logic [XLEN-1:0] b_rs1,
    input  logic [XLEN-1:0] b_rs2,
    input  logic [6:0]      b_opcode,
    input  logic [2:0]      b_func3,
    input  logic [6:0]      b_func7,

    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [6:0]      alu_opcode,
    output logic [2:0]      alu_func3,
    output logic [6:0]      alu_func7,
    input  logic [XLEN-1:0] alu_out,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Packed request payload: {rs1, rs2, opcode, func3, func7}
    localparam int FW = 2 * XLEN + 17;

    state_t          state_reg;
    logic            rr_ptr_reg;    // requester favoured on contention (0 = A)
    logic            grant_id_reg;  // requester whose operation is in flight

    logic [XLEN-1:0] alu_rs1_reg;
    logic [XLEN-1:0] alu_rs2_reg;
    logic [6:0]      alu_opcode_reg;
    logic [2:0]      alu_func3_reg;
    logic [6:0]      alu_func7_reg;
    logic            rsp_valid_reg;
    logic            rsp_id_reg;
    logic [XLEN-1:0] rsp_data_reg;

    logic [1:0]      req_valid;
    logic [1:0]      grant;
    logic [1:0]      req_ready;
    logic [FW-1:0]   req_bus [2];
    logic [FW-1:0]   sel_bus;
    logic            in_idle;
    logic            accept;

    assign req_valid  = {b_req_valid, a_req_valid};
    assign req_bus[0] = {a_rs1, a_rs2, a_opcode, a_func3, a_func7};
    assign req_bus[1] = {b_rs1, b_rs2, b_opcode, b_func3, b_func7};
    assign in_idle    = (state_reg == IDLE);

    // A requester wins if it is the only one asking, or if both ask and the
    // round-robin pointer favours it. The two grants are mutually exclusive by
    // construction. Ready is gated with rst_n so nothing is offered while the
    // block is held in reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = req_valid[gi] &
                               (~req_valid[1-gi] | (rr_ptr_reg == 1'(gi)));
            assign req_ready[gi] = rst_n & in_idle & grant[gi];
        end
    endgenerate

    assign a_req_ready = req_ready[0];
    assign b_req_ready = req_ready[1];
    assign accept      = |req_ready;
    assign sel_bus     = grant[1] ? req_bus[1] : req_bus[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= 1'b0;
            grant_id_reg   <= 1'b0;
            alu_rs1_reg    <= '0;
            alu_rs2_reg    <= '0;
            alu_opcode_reg <= '0;
            alu_func3_reg  <= '0;
            alu_func7_reg  <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_data_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // alu_* keep their last values when nothing is accepted
                    if (accept) begin
                        {alu_rs1_reg, alu_rs2_reg, alu_opcode_reg,
                         alu_func3_reg, alu_func7_reg} <= sel_bus;
                        grant_id_reg <= grant[1];
                        rr_ptr_reg   <= ~grant[1];  // point at the other side
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands have had a full cycle through the ALU
                    rsp_data_reg  <= alu_out;
                    rsp_id_reg    <= grant_id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign alu_rs1    = alu_rs1_reg;
    assign alu_rs2    = alu_rs2_reg;
    assign alu_opcode = alu_opcode_reg;
    assign alu_func3  = alu_func3_reg;
    assign alu_func7  = alu_func7_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_data   = rsp_data_reg;
    assign busy       = ~in_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. A small behavioural ALU sits on the alu_* bus. Every
// accepted request pushes its expected response onto a queue; a negedge
// monitor checks ready/busy against a transaction-level arbitration model and
// compares every presented response with the queue head.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a_req_valid, b_req_valid;
    logic            a_req_ready, b_req_ready;
    logic [XLEN-1:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic [6:0]      a_opcode, b_opcode, a_func7, b_func7;
    logic [2:0]      a_func3, b_func3;
    logic [XLEN-1:0] alu_rs1, alu_rs2, alu_out;
    logic [6:0]      alu_opcode, alu_func7;
    logic [2:0]      alu_func3;
    logic            rsp_valid, rsp_ready, rsp_id, busy;
    logic [XLEN-1:0] rsp_data;

    always #5 clk = ~clk;

    // Behavioural ALU: R-type ops on 0x33, add-immediate style on 0x13,
    // everything else yields 0.
    function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
        if (op == 7'h33) begin
            case (f3)
                3'd0:    return (f7 == 7'h20) ? x - y : x + y;
                3'd1:    return x << y[4:0];
                3'd4:    return x ^ y;
                3'd5:    return x >> y[4:0];
                3'd6:    return x | y;
                3'd7:    return x & y;
                default: return 32'd0;
            endcase
        end else if (op == 7'h13) begin
            return x + y;
        end
        return 32'd0;
    endfunction

    assign alu_out = alu_fn(alu_rs1, alu_rs2, alu_opcode, alu_func3, alu_func7);

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
        .a_rs1(a_rs1), .a_rs2(a_rs2), .a_opcode(a_opcode), .a_func3(a_func3), .a_func7(a_func7),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
        .b_rs1(b_rs1), .b_rs2(b_rs2), .b_opcode(b_opcode), .b_func3(b_func3), .b_func7(b_func7),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode),
        .alu_func3(alu_func3), .alu_func7(alu_func7), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_tmp;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          pop_count = 0;
    int          b_pops    = 0;
    bit          favor_b   = 1'b0;   // model: B wins the next contention
    bit          rsp_valid_prev = 1'b0;
    bit          a_hs_last = 1'b0, b_hs_last = 1'b0;
    bit          idle_m, exp_ra, exp_rb;
    logic        last_id;
    logic [31:0] last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            // Arbitration model: the arbiter is idle exactly when nothing is outstanding
            idle_m = (exp_q.size() == 0);
            exp_ra = idle_m && a_req_valid && (!b_req_valid || !favor_b);
            exp_rb = idle_m && b_req_valid && (!a_req_valid || favor_b);
            chk("a_req_ready", a_req_ready, exp_ra);
            chk("b_req_ready", b_req_ready, exp_rb);
            chk("busy", busy, !idle_m);

            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", rsp_valid, 0);
                end else begin
                    chk("rsp_id", rsp_id, exp_q[0].id);
                    chk("rsp_data", rsp_data, exp_q[0].data);
                    if (!rsp_valid_prev)
                        chk("rsp_latency", cyc - exp_q[0].cyc, 2);
                    if (rsp_ready) begin
                        last_id   = rsp_id;
                        last_data = rsp_data;
                        $display("rsp id=%0d data=0x%08h cycle=%0d", rsp_id, rsp_data, cyc);
                        void'(exp_q.pop_front());
                        pop_count++;
                        if (rsp_id) b_pops++;
                    end
                end
            end

            a_hs_last = a_req_valid && a_req_ready;
            b_hs_last = b_req_valid && b_req_ready;
            if (a_hs_last) begin
                e_tmp.id = 1'b0;
                e_tmp.data = alu_fn(a_rs1, a_rs2, a_opcode, a_func3, a_func7);
                e_tmp.cyc = cyc;
                exp_q.push_back(e_tmp);
                favor_b = 1'b1;
            end
            if (b_hs_last) begin
                e_tmp.id = 1'b1;
                e_tmp.data = alu_fn(b_rs1, b_rs2, b_opcode, b_func3, b_func7);
                e_tmp.cyc = cyc;
                exp_q.push_back(e_tmp);
                favor_b = 1'b0;
            end
            rsp_valid_prev = rsp_valid;
        end else begin
            // Reset abandons anything in flight and re-favours A
            exp_q.delete();
            favor_b        = 1'b0;
            rsp_valid_prev = 1'b0;
            a_hs_last      = 1'b0;
            b_hs_last      = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_a_ready"}, a_req_ready, 0);
        chk({tag, "_b_ready"}, b_req_ready, 0);
        chk({tag, "_alu_rs1"}, alu_rs1, 0);
        chk({tag, "_alu_rs2"}, alu_rs2, 0);
        chk({tag, "_alu_opcode"}, alu_opcode, 0);
        chk({tag, "_alu_func3"}, alu_func3, 0);
        chk({tag, "_alu_func7"}, alu_func7, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
    endtask

    // Pulse reset from a point just after a rising edge; returns at posedge+1
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_a(input logic [31:0] x, input logic [31:0] y, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7);
        a_rs1 = x; a_rs2 = y; a_opcode = op; a_func3 = f3; a_func7 = f7; a_req_valid = 1'b1;
    endtask

    task automatic set_b(input logic [31:0] x, input logic [31:0] y, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7);
        b_rs1 = x; b_rs2 = y; b_opcode = op; b_func3 = f3; b_func7 = f7; b_req_valid = 1'b1;
    endtask

    // Wait (bounded) for the handshake of one side, then drop its valid
    task automatic wait_hs(input bit side);
        int k = 0;
        bit got = 1'b0;
        while (!got && k < 50) begin
            @(negedge clk);
            got = side ? (b_req_valid && b_req_ready) : (a_req_valid && a_req_ready);
            k++;
        end
        chk("handshake_timeout", got, 1);
        @(posedge clk);
        #1;
        if (side) b_req_valid = 1'b0;
        else      a_req_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int k = 0;
        while (pop_count < n && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("response_timeout", pop_count >= n, 1);
    endtask

    task automatic drain();
        int k = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic rand_a();
        a_rs1 = $urandom; a_rs2 = $urandom;
        a_opcode = ($urandom_range(0, 3) < 2) ? 7'h33 : (($urandom_range(0, 1) == 0) ? 7'h13 : 7'($urandom));
        a_func3 = 3'($urandom);
        a_func7 = ($urandom_range(0, 1) == 0) ? 7'h20 : 7'($urandom);
    endtask

    task automatic rand_b();
        b_rs1 = $urandom; b_rs2 = $urandom;
        b_opcode = ($urandom_range(0, 3) < 2) ? 7'h33 : (($urandom_range(0, 1) == 0) ? 7'h13 : 7'($urandom));
        b_func3 = 3'($urandom);
        b_func7 = ($urandom_range(0, 1) == 0) ? 7'h20 : 7'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p, bp, k;
        rst_n = 1'b0;
        a_req_valid = 0; b_req_valid = 0; rsp_ready = 0;
        a_rs1 = 0; a_rs2 = 0; a_opcode = 0; a_func3 = 0; a_func7 = 0;
        b_rs1 = 0; b_rs2 = 0; b_opcode = 0; b_func3 = 0; b_func7 = 0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single ADD from A
        rsp_ready = 1'b1;
        p = pop_count;
        set_a(5, 7, 7'h33, 3'd0, 7'h00);
        wait_hs(0);
        wait_pops(p + 1);
        chk("t1_id", last_id, 0);
        chk("t1_data", last_data, 32'd12);

        // 2: SUB from B
        p = pop_count;
        set_b(5, 7, 7'h33, 3'd0, 7'h20);
        wait_hs(1);
        wait_pops(p + 1);
        chk("t2_id", last_id, 1);
        chk("t2_data", last_data, 32'hFFFF_FFFE);

        // 3: contention, both valid straight out of reset
        set_a(1, 1, 7'h33, 3'd0, 7'h00);
        set_b(32'hF0, 32'h0F, 7'h33, 3'd4, 7'h00);
        do_reset();
        p = pop_count;
        wait_pops(p + 1);
        chk("t3_first_id", last_id, 0);
        chk("t3_first_data", last_data, 32'd2);
        wait_pops(p + 2);
        chk("t3_second_id", last_id, 1);
        chk("t3_second_data", last_data, 32'hFF);
        wait_pops(p + 3);
        chk("t3_third_id", last_id, 0);
        chk("t3_third_data", last_data, 32'd2);
        a_req_valid = 0;
        b_req_valid = 0;
        drain();

        // 4: backpressure with B waiting
        rsp_ready = 1'b0;
        set_a(32'h100, 32'h23, 7'h33, 3'd0, 7'h00);
        wait_hs(0);
        set_b(32'h1F, 32'h3, 7'h33, 3'd7, 7'h00);
        k = 0;
        while (!rsp_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t4_rsp_valid_seen", rsp_valid, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_data", rsp_data, 32'h123);
            chk("t4_hold_b_ready", b_req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_b_ready_at_release", b_req_ready, 0);
        @(posedge clk);
        #1;
        chk("t4_b_ready_after", b_req_ready, 1);
        p = pop_count;
        wait_hs(1);
        wait_pops(p + 1);
        chk("t4_b_id", last_id, 1);
        chk("t4_b_data", last_data, 32'd3);

        // 5: reset during EXEC
        set_a(9, 4, 7'h33, 3'd0, 7'h00);
        wait_hs(0);            // returns one unit after the accepting edge: EXEC
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_midop");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        p = pop_count;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_no_stale_rsp", pop_count, p);
        set_a(9, 4, 7'h33, 3'd0, 7'h00);
        wait_hs(0);
        wait_pops(p + 1);
        chk("t5_after_id", last_id, 0);
        chk("t5_after_data", last_data, 32'd13);

        // 6: B abandons while A is served
        do_reset();
        bp = b_pops;
        set_a(3, 4, 7'h33, 3'd0, 7'h00);
        set_b(2, 9, 7'h33, 3'd0, 7'h00);
        wait_hs(0);
        b_req_valid = 1'b0;
        drain();
        chk("t6_no_b_rsp", b_pops, bp);
        chk("t6_a_data", last_data, 32'd7);
        p = pop_count;
        set_a(1, 1, 7'h33, 3'd0, 7'h00);
        set_b(2, 2, 7'h33, 3'd0, 7'h00);
        wait_pops(p + 1);
        chk("t6_rr_first_id", last_id, 1);
        chk("t6_rr_first_data", last_data, 32'd4);
        wait_pops(p + 2);
        chk("t6_rr_second_id", last_id, 0);
        chk("t6_rr_second_data", last_data, 32'd2);
        a_req_valid = 0;
        b_req_valid = 0;
        drain();

        // Random traffic with random backpressure and abandoned requests
        for (int i = 0; i < 400; i++) begin
            if (!a_req_valid || a_hs_last) begin
                if ($urandom_range(0, 2) != 0) begin rand_a(); a_req_valid = 1'b1; end
                else a_req_valid = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                a_req_valid = 1'b0;
            end
            if (!b_req_valid || b_hs_last) begin
                if ($urandom_range(0, 2) != 0) begin rand_b(); b_req_valid = 1'b1; end
                else b_req_valid = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                b_req_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        a_req_valid = 0;
        b_req_valid = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
